alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Round-robin scheduler that shares one combinational ALU (32-bit operands, 3-bit opcode, 33-bit result, `en`/`ack` handshake) between NREQ requesters. It captures a winning request's operands, drives the ALU for one operation, and registers the result. It returns the result with a one-cycle `done` strobe to the winner. Divide-by-zero modulo is rejected without touching the ALU, and an ALU that never acknowledges is timed out.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 32, operand width; result is WIDTH+1
- TIMEOUT, 8, max EXEC cycles waiting for `alu_ack` before error
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- req  input  NREQ  per-requester request level
- req_op  input  3*NREQ  opcode of requester i at bits [3i+2:3i]
- req_a  input  WIDTH*NREQ  operand a of requester i
- req_b  input  WIDTH*NREQ  operand b of requester i
- gnt  output  NREQ  one-hot, one-cycle pulse: operands of i captured
- done  output  NREQ  one-hot, one-cycle pulse: rsp_result/rsp_err valid for i
- rsp_result  output  WIDTH+1  registered ALU result
- rsp_err  output  1  valid with done; 1 = div-by-zero or timeout
- busy  output  1  high in any state other than IDLE
- alu_en  output  1  ALU enable
- alu_opcode  output  3  ALU opcode
- alu_a, alu_b  output  WIDTH each  ALU operands
- alu_result  input  WIDTH+1  ALU result
- alu_ack  input  1  ALU acknowledge

## Operation
- States: IDLE, EXEC, RESP. All outputs are registered or decoded from state and registers only.
- IDLE: if `req` != 0, select the first set bit searching from ptr+1 upward, modulo NREQ. Then:
  - Latch that requester's op/a/b and set ptr = winner.
  - Pulse gnt[winner] in the next cycle.
  - If op==3'b010 and b==0, go to RESP with err=1, result=0. `alu_en` is never asserted.
  - Otherwise go to EXEC with the timeout count cleared.
- EXEC: `alu_en`=1, `alu_opcode/alu_a/alu_b` = latched values.
  - If `alu_ack`==1: register `alu_result` into rsp_result, err=0, go to RESP.
  - Else if count==TIMEOUT-1: rsp_result=0, err=1, go to RESP.
  - Else increment count.
- RESP: done[winner]=1 with rsp_result/rsp_err valid, then go to IDLE.
- `alu_en`=0 in IDLE and RESP. `alu_a/alu_b/alu_opcode` hold their latched values; the ALU output is don't-care while disabled.
- Requester protocol: hold req/op/a/b stable until gnt. Drop req in the gnt cycle unless issuing a new op. A req still high in IDLE is treated as a new request.
- Arithmetic is performed by the ALU. rsp_result is the full WIDTH+1 bits, unmodified: add carry in bit 32, sub wraps mod 2^33, logical/compare ops give 0 or 1.
- rsp_result and rsp_err hold their values after RESP until the next RESP.

## Timing
- Reset (next edge): state=IDLE, ptr=NREQ-1 (requester 0 has highest priority first), gnt=0, done=0, rsp_result=0, rsp_err=0, busy=0, alu_en=0, alu_opcode=0, alu_a=0, alu_b=0, count=0.
- Reset mid-EXEC or RESP: abort. No done is issued for the aborted op and `alu_en` is 0 from the cycle after reset.
- Req sampled in IDLE at edge N:
  - gnt and EXEC during cycle N+1.
  - With immediate ack: done during cycle N+2.
  - Best throughput is one op per 3 cycles.
- With ack after k EXEC cycles (k ≤ TIMEOUT): done at N+1+k.
- Timeout: EXEC lasts exactly TIMEOUT cycles, then done with err.
- Div-by-zero: gnt at N+1 coincides with RESP, so done is also at N+1.
- Requests arriving in EXEC/RESP wait; no request is lost while req is held.
- With all req held, grant order is 0,1,2,…,NREQ-1,0,…

## Test plan
- After reset, req[0] with op 000, a=5, b=7 -> gnt[0] at N+1, done[0] at N+2, rsp_result=12, rsp_err=0.
- req[2] with op 001, a=0, b=1 -> rsp_result=33'h1_FFFF_FFFF. req[1] with op 000, a=b=32'hFFFF_FFFF -> rsp_result=33'h1_FFFF_FFFE.
- All four req held from reset -> gnt sequence 0,1,2,3,0 at 3-cycle spacing. Each done carries its own requester's result.
- req[3] with op 010, b=0 -> done[3] with rsp_err=1 and rsp_result=0. `alu_en` never goes high. Op 010 with a=17, b=5 -> rsp_result=2.
- ALU model holds ack=0 -> `alu_en` high for exactly 8 cycles, then done with err=1. Next request still completes normally.
- rst asserted during EXEC -> next cycle state IDLE, alu_en=0, no done, ptr=NREQ-1. A pending req[1] is granted afterwards.

Source files
------------

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Round-robin scheduler that shares one combinational ALU between NREQ
//   requesters. In IDLE it picks a winner, starting the search just after the
//   last winner. It latches the winner's op/a/b and drives the ALU through the
//   en/ack handshake. The result is returned with a one-cycle done strobe. A
//   modulo with b==0 is rejected without enabling the ALU. An ALU that never
//   acks is cut off after TIMEOUT EXEC cycles.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   req             per-requester request level
//   req_op          opcode of requester i at [3i+2:3i]
//   req_a, req_b    operands of requester i at [WIDTH*i +: WIDTH]
//   gnt             one-hot pulse: operands of requester i captured
//   done            one-hot pulse: rsp_result/rsp_err valid for requester i
//   rsp_result      registered WIDTH+1 result (held until the next RESP)
//   rsp_err         1 = div-by-zero or timeout, valid with done
//   busy            high whenever not IDLE
//   alu_en          ALU enable (EXEC only)
//   alu_opcode/a/b  latched operation presented to the ALU
//   alu_result      ALU result
//   alu_ack         ALU acknowledge
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [3*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_a,
  input  logic [WIDTH*NREQ-1:0] req_b,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH:0]        rsp_result,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  alu_en,
  output logic [2:0]            alu_opcode,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  input  logic [WIDTH:0]        alu_result,
  input  logic                  alu_ack
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [2:0] OP_MOD = 3'b010;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t            r_state;
  logic [PW-1:0]     r_ptr;
  logic [NREQ-1:0]   r_win_oh;
  logic [NREQ-1:0]   r_gnt;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_op;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH:0]    r_result;
  logic              r_err;

  logic              w_found;
  logic [PW-1:0]     w_win;
  logic [NREQ-1:0]   w_win_oh;
  logic [2:0]        w_op;
  logic [WIDTH-1:0]  w_a;
  logic [WIDTH-1:0]  w_b;
  logic              w_div0;
  logic              w_last;

  // Round-robin pick: the first requester at or after ptr+1, wrapping. The
  // operand mux is folded into the same scan so the winner's fields come out
  // together with its index.
  always_comb begin
    int idx;
    idx      = 0;
    w_found  = 1'b0;
    w_win    = '0;
    w_win_oh = '0;
    w_op     = '0;
    w_a      = '0;
    w_b      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(r_ptr) + k) % NREQ;
      if (!w_found && req[idx]) begin
        w_found       = 1'b1;
        w_win         = PW'(idx);
        w_win_oh[idx] = 1'b1;
        w_op          = req_op[3*idx +: 3];
        w_a           = req_a[WIDTH*idx +: WIDTH];
        w_b           = req_b[WIDTH*idx +: WIDTH];
      end
    end
  end

  assign w_div0 = (w_op == OP_MOD) && (w_b == '0);
  assign w_last = (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ptr    <= PW'(NREQ - 1);   // requester 0 wins first after reset
      r_win_oh <= '0;
      r_gnt    <= '0;
      r_cnt    <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      r_gnt <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_ptr    <= w_win;
            r_win_oh <= w_win_oh;
            r_gnt    <= w_win_oh;
            r_op     <= w_op;
            r_a      <= w_a;
            r_b      <= w_b;
            r_cnt    <= '0;
            if (w_div0) begin
              // Rejected up front: the ALU is never enabled, and the gnt
              // and done pulses land in the same cycle.
              r_result <= '0;
              r_err    <= 1'b1;
              r_state  <= S_RESP;
            end else begin
              r_state  <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          // An ack on the last allowed cycle still counts as success.
          if (alu_ack) begin
            r_result <= alu_result;
            r_err    <= 1'b0;
            r_state  <= S_RESP;
          end else if (w_last) begin
            r_result <= '0;
            r_err    <= 1'b1;
            r_state  <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt        = r_gnt;
  assign done       = (r_state == S_RESP) ? r_win_oh : '0;
  assign rsp_result = r_result;
  assign rsp_err    = r_err;
  assign busy       = (r_state != S_IDLE);
  assign alu_en     = (r_state == S_EXEC);
  assign alu_opcode = r_op;
  assign alu_a      = r_a;
  assign alu_b      = r_b;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [3*NREQ-1:0] req_op;
  logic [W*NREQ-1:0] req_a, req_b;
  logic [NREQ-1:0]   gnt, done;
  logic [W:0]        rsp_result;
  logic              rsp_err, busy, alu_en;
  logic [2:0]        alu_opcode;
  logic [W-1:0]      alu_a, alu_b;
  logic [W:0]        alu_result;
  logic              alu_ack;

  logic [NREQ-1:0]   req_v;
  logic [2:0]        op_v [NREQ];
  logic [W-1:0]      a_v  [NREQ];
  logic [W-1:0]      b_v  [NREQ];

  int n_checks = 0;
  int n_fail   = 0;
  int ecnt     = 0;
  int ack_dly  = 1;
  logic ack_never = 1'b0;

  alu_arbiter #(.NREQ(NREQ), .WIDTH(W), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .done(done), .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy),
    .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_ack(alu_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req = req_v;
    for (int i = 0; i < NREQ; i++) begin
      req_op[3*i +: 3] = op_v[i];
      req_a[W*i +: W]  = a_v[i];
      req_b[W*i +: W]  = b_v[i];
    end
  end

  // ALU model: 000 add, 001 sub, 010 mod, 011 less-than; ack after ack_dly
  // consecutive enabled cycles unless ack_never.
  always_comb begin
    case (alu_opcode)
      3'b000:  alu_result = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001:  alu_result = {1'b0, alu_a} - {1'b0, alu_b};
      3'b010:  alu_result = (alu_b == 0) ? '0 : {1'b0, alu_a % alu_b};
      3'b011:  alu_result = {32'b0, alu_a < alu_b};
      default: alu_result = '0;
    endcase
  end
  assign alu_ack = alu_en && !ack_never && (ecnt == ack_dly - 1);
  always @(posedge clk) begin
    if (alu_en) ecnt <= ecnt + 1;
    else        ecnt <= 0;
  end

  task automatic test_reset();
    rst = 1'b1; req_v = '0;
    for (int i = 0; i < NREQ; i++) begin op_v[i] = '0; a_v[i] = '0; b_v[i] = '0; end
    repeat (2) @(negedge clk);
    n_checks++; if (gnt !== 4'b0 || done !== 4'b0) begin n_fail++; $display("FAIL reset_gnt_done: gnt=%b done=%b want 0", gnt, done); end
    n_checks++; if (rsp_result !== 33'h0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp: result=%h err=%b want 0", rsp_result, rsp_err); end
    n_checks++; if (busy !== 1'b0 || alu_en !== 1'b0) begin n_fail++; $display("FAIL reset_busy_en: busy=%b en=%b want 0", busy, alu_en); end
    n_checks++; if (alu_opcode !== 3'b0 || alu_a !== 32'h0 || alu_b !== 32'h0) begin n_fail++; $display("FAIL reset_alu_ops: op=%h a=%h b=%h want 0", alu_opcode, alu_a, alu_b); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Issue one request in IDLE, check gnt, done latency, result and enable count.
  task automatic do_op(input string name, input int id, input logic [2:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W:0] exp_res, input logic exp_err,
                       input int exp_lat, input int exp_en);
    logic [NREQ-1:0] oh;
    int lat, en_cnt;
    oh = 4'b0001 << id;
    req_v[id] = 1'b1; op_v[id] = op; a_v[id] = a; b_v[id] = b;
    @(negedge clk);
    n_checks++; if (gnt !== oh) begin n_fail++; $display("FAIL %s gnt: got %b want %b", name, gnt, oh); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s busy: got %b want 1", name, busy); end
    req_v[id] = 1'b0;
    lat = 1; en_cnt = alu_en ? 1 : 0;
    while (done === 4'b0 && lat < 40) begin
      @(negedge clk); lat++;
      if (alu_en) en_cnt++;
    end
    n_checks++; if (done !== oh) begin n_fail++; $display("FAIL %s done: got %b want %b", name, done, oh); end
    n_checks++; if (lat != exp_lat) begin n_fail++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat); end
    n_checks++; if (rsp_result !== exp_res) begin n_fail++; $display("FAIL %s result: got %h want %h", name, rsp_result, exp_res); end
    n_checks++; if (rsp_err !== exp_err) begin n_fail++; $display("FAIL %s err: got %b want %b", name, rsp_err, exp_err); end
    n_checks++; if (en_cnt != exp_en) begin n_fail++; $display("FAIL %s alu_en_cycles: got %0d want %0d", name, en_cnt, exp_en); end
    @(negedge clk);
    n_checks++; if (rsp_result !== exp_res || busy !== 1'b0 || done !== 4'b0) begin n_fail++; $display("FAIL %s hold: result=%h busy=%b done=%b want %h 0 0", name, rsp_result, busy, done, exp_res); end
  endtask

  task automatic test_basic();
    do_op("add_basic", 0, 3'b000, 32'd5, 32'd7, 33'd12, 1'b0, 2, 1);
  endtask

  task automatic test_sub_wrap();
    do_op("sub_wrap", 2, 3'b001, 32'd0, 32'd1, 33'h1_FFFF_FFFF, 1'b0, 2, 1);
  endtask

  task automatic test_add_carry();
    do_op("add_carry", 1, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE, 1'b0, 2, 1);
  endtask

  task automatic test_divzero();
    do_op("div_zero", 3, 3'b010, 32'd9, 32'd0, 33'd0, 1'b1, 1, 0);
    do_op("mod_ok", 3, 3'b010, 32'd17, 32'd5, 33'd2, 1'b0, 2, 1);
  endtask

  task automatic test_timeout();
    ack_never = 1'b1;
    do_op("timeout", 0, 3'b000, 32'd1, 32'd2, 33'd0, 1'b1, 9, 8);
    ack_never = 1'b0;
    do_op("after_timeout", 1, 3'b000, 32'd3, 32'd4, 33'd7, 1'b0, 2, 1);
  endtask

  task automatic test_delayed_ack();
    ack_dly = 3;
    do_op("ack_k3", 2, 3'b001, 32'd50, 32'd8, 33'd42, 1'b0, 4, 3);
    ack_dly = 8;
    do_op("ack_k8", 0, 3'b000, 32'd10, 32'd20, 33'd30, 1'b0, 9, 8);
    ack_dly = 1;
  endtask

  task automatic test_round_robin();
    int ng, prev, cyc, dj;
    logic [NREQ-1:0] exp_oh;
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin op_v[i] = 3'b000; a_v[i] = 100 + i; b_v[i] = i; end
    req_v = 4'hF;
    @(negedge clk);
    rst = 1'b0;
    ng = 0; prev = 0; cyc = 0;
    while (ng < 5 && cyc < 40) begin
      @(negedge clk); cyc++;
      if (done !== 4'b0) begin
        dj = 0;
        for (int j = 0; j < NREQ; j++) if (done[j]) dj = j;
        n_checks++; if (rsp_result !== 33'(100 + 2*dj)) begin n_fail++; $display("FAIL rr_result[%0d]: got %0d want %0d", dj, rsp_result, 100 + 2*dj); end
      end
      if (gnt !== 4'b0) begin
        exp_oh = 4'b0001 << (ng % NREQ);
        n_checks++; if (gnt !== exp_oh) begin n_fail++; $display("FAIL rr_order[%0d]: got %b want %b", ng, gnt, exp_oh); end
        if (ng > 0) begin
          n_checks++; if (cyc - prev != 3) begin n_fail++; $display("FAIL rr_spacing[%0d]: got %0d want 3", ng, cyc - prev); end
        end
        prev = cyc; ng++;
      end
    end
    n_checks++; if (ng != 5) begin n_fail++; $display("FAIL rr_count: got %0d grants want 5", ng); end
    req_v = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_exec();
    int t;
    ack_never = 1'b1;
    req_v[2] = 1'b1; op_v[2] = 3'b000; a_v[2] = 32'd1; b_v[2] = 32'd1;
    @(negedge clk);
    n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL rme_gnt2: got %b want 0100", gnt); end
    req_v[2] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    req_v[1] = 1'b1; op_v[1] = 3'b000; a_v[1] = 32'd20; b_v[1] = 32'd2;
    req_v[3] = 1'b1; op_v[3] = 3'b000; a_v[3] = 32'd30; b_v[3] = 32'd3;
    @(negedge clk);
    n_checks++; if (alu_en !== 1'b0 || busy !== 1'b0 || done !== 4'b0 || gnt !== 4'b0) begin n_fail++; $display("FAIL rme_abort: en=%b busy=%b done=%b gnt=%b want all 0", alu_en, busy, done, gnt); end
    rst = 1'b0; ack_never = 1'b0;
    @(negedge clk);
    // ptr back at NREQ-1, so requester 1 wins over 3
    n_checks++; if (gnt !== 4'b0010 || done !== 4'b0) begin n_fail++; $display("FAIL rme_gnt1: gnt=%b done=%b want 0010 0000", gnt, done); end
    req_v[1] = 1'b0;
    t = 0;
    while (done === 4'b0 && t < 20) begin @(negedge clk); t++; end
    n_checks++; if (done !== 4'b0010 || rsp_result !== 33'd22 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL rme_done1: done=%b result=%0d err=%b want 0010 22 0", done, rsp_result, rsp_err); end
    t = 0;
    while (gnt === 4'b0 && t < 20) begin @(negedge clk); t++; end
    n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL rme_gnt3: got %b want 1000", gnt); end
    req_v[3] = 1'b0;
    t = 0;
    while (done === 4'b0 && t < 20) begin @(negedge clk); t++; end
    n_checks++; if (done !== 4'b1000 || rsp_result !== 33'd33) begin n_fail++; $display("FAIL rme_done3: done=%b result=%0d want 1000 33", done, rsp_result); end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req_v = '0;
    test_reset();
    test_basic();
    test_sub_wrap();
    test_add_carry();
    test_divzero();
    test_timeout();
    test_delayed_ack();
    test_round_robin();
    test_reset_mid_exec();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
